// File: rtl/maze_mem.sv
// Maze storage beside the wall-follower solver: host-loaded wall plane, solver-written
// visited plane with a distinct-cell count, and a row-by-row dump of the visited plane.
module maze_mem #(
  parameter int maze_width = 6,
  parameter int maze_dim   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [maze_dim-1:0]     load_data,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  input  logic                    done,
  output logic                    maze_in,
  output logic                    loaded,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [maze_dim-1:0]     dump_data,
  output logic [maze_width-1:0]   dump_row,
  output logic [2*maze_width:0]   visit_count,
  output logic                    finished
);
  localparam int CW = 2*maze_width+1;
  localparam logic [maze_dim-1:0] ONE = 1;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DUMP, S_FIN} state_t;
  state_t r_state;

  logic [maze_dim-1:0]   r_wall [maze_dim];
  logic [maze_dim-1:0]   r_vis  [maze_dim];
  logic [maze_dim-1:0]   r_rowv;
  logic [maze_width-1:0] r_load_ptr;

  logic                  w_load_xfer;
  logic                  w_we;
  logic [maze_dim-1:0]   w_col_mask;
  logic [maze_dim-1:0]   w_vis_row;
  logic [maze_dim-1:0]   w_row0;
  logic [maze_width-1:0] w_dump_nxt;
  logic [maze_dim-1:0]   w_dump_rd;

  // Rows whose valid bit is clear read as all-unvisited; this stands in for clearing the plane.
  assign w_load_xfer = (r_state == S_LOAD) && load_ready && load_valid;
  assign w_we        = (r_state == S_RUN) && maze_we;
  assign w_col_mask  = ONE << col;
  assign w_vis_row   = r_rowv[row] ? r_vis[row] : '0;
  assign w_row0      = (r_rowv[0] ? r_vis[0] : '0) |
                       ((w_we && (row == '0)) ? w_col_mask : '0);
  assign w_dump_nxt  = dump_row + maze_width'(1);
  assign w_dump_rd   = r_rowv[w_dump_nxt] ? r_vis[w_dump_nxt] : '0;

  always_ff @(posedge clk) begin
    if (w_load_xfer) r_wall[r_load_ptr] <= load_data;
    if (w_we)        r_vis[row]         <= w_vis_row | w_col_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_rowv      <= '0;
      r_load_ptr  <= '0;
      load_ready  <= 1'b0;
      loaded      <= 1'b0;
      maze_in     <= 1'b0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_row    <= '0;
      visit_count <= '0;
      finished    <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (!load_ready) begin
            load_ready <= 1'b1;
          end else if (load_valid) begin
            r_load_ptr <= r_load_ptr + maze_width'(1);
            if (r_load_ptr == maze_width'(maze_dim-1)) begin
              load_ready <= 1'b0;
              loaded     <= 1'b1;
              r_state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (maze_oe) maze_in <= r_wall[row][col];
          if (w_we) begin
            r_rowv[row] <= 1'b1;
            if (!w_vis_row[col]) visit_count <= visit_count + CW'(1);
          end
          // Row 0 snapshot folds in a same-cycle write so the final move is not lost.
          if (done) begin
            r_state    <= S_DUMP;
            dump_row   <= '0;
            dump_valid <= 1'b1;
            dump_data  <= w_row0;
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (dump_row == maze_width'(maze_dim-1)) begin
              dump_valid <= 1'b0;
              finished   <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              dump_row  <= w_dump_nxt;
              dump_data <= w_dump_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_mem.sv
// Directed bench for maze_mem: load, read latency, visit counting, dump, and reset mid-load.
module tb_maze_mem;
  localparam int MW = 6;
  localparam int MD = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [MD-1:0] load_data = '0;
  logic [MW-1:0] row = '0;
  logic [MW-1:0] col = '0;
  logic          maze_oe = 1'b0;
  logic          maze_we = 1'b0;
  logic          done = 1'b0;
  logic          maze_in;
  logic          loaded;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [MD-1:0] dump_data;
  logic [MW-1:0] dump_row;
  logic [2*MW:0] visit_count;
  logic          finished;

  int checks = 0;
  int errors = 0;
  int rdy, cyc;

  maze_mem #(.maze_width(MW), .maze_dim(MD)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we), .done(done),
    .maze_in(maze_in), .loaded(loaded),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_row(dump_row), .visit_count(visit_count), .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 0: bordered maze with an opening at [0][5]; 1: all walls; 2: diagonal
  function automatic logic [63:0] pat_row(input int pat, input int r);
    logic [63:0] one;
    one = 64'h1;
    case (pat)
      0: begin
        if (r == 0) return ~(one << 5);
        if (r == MD-1) return '1;
        return 64'h8000_0000_0000_0001;
      end
      1: return '1;
      default: return (r < MD) ? (one << r) : '0;
    endcase
  endfunction

  task automatic load_rows(input int nrows, input int pat, input bit toggle,
                           output int ready_cyc, output int cycles);
    int n;
    bit x;
    n = 0; ready_cyc = 0; cycles = 0;
    load_valid = 1'b1;
    load_data  = pat_row(pat, 0);
    while (n < nrows && cycles < 400) begin
      @(negedge clk);
      if (load_ready) ready_cyc++;
      x = load_valid && load_ready;
      @(posedge clk); #1;
      cycles++;
      if (x) begin
        n++;
        load_data = pat_row(pat, n);
      end
      if (toggle) load_valid = ~load_valid;
    end
    load_valid = 1'b0;
    check("load_xfers", 64'(n), 64'(nrows));
  endtask

  task automatic do_read(input int r, input int c, input logic exp, input string tag);
    row = MW'(r); col = MW'(c); maze_oe = 1'b1;
    @(posedge clk); #1;
    maze_oe = 1'b0;
    check(tag, 64'(maze_in), 64'(exp));
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    check("rst_dump_valid", 64'(dump_valid), 64'd0);
    check("rst_vcount", 64'(visit_count), 64'd0);
    check("rst_finished", 64'(finished), 64'd0);
    release_rst();

    load_rows(MD, 0, 1'b0, rdy, cyc);
    check("load_ready_cycles", 64'(rdy), 64'd64);
    check("load_cycles", 64'(cyc), 64'd65);
    check("loaded_after", 64'(loaded), 64'd1);
    check("ready_drop", 64'(load_ready), 64'd0);

    do_read(0, 5, 1'b0, "rd_0_5");
    do_read(0, 6, 1'b1, "rd_0_6");
    @(posedge clk); #1;
    check("rd_hold1", 64'(maze_in), 64'd1);
    @(posedge clk); #1;
    check("rd_hold2", 64'(maze_in), 64'd1);

    row = 3; col = 3; maze_we = 1'b1;
    @(posedge clk); #1;
    check("vc_first", 64'(visit_count), 64'd1);
    @(posedge clk); #1;
    check("vc_rewrite", 64'(visit_count), 64'd1);
    col = 4; maze_oe = 1'b1;
    @(posedge clk); #1;
    maze_we = 1'b0; maze_oe = 1'b0;
    check("vc_second", 64'(visit_count), 64'd2);
    check("rd_3_4", 64'(maze_in), 64'd0);

    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    check("dump_valid_start", 64'(dump_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("dump_hold_row", 64'(dump_row), 64'd0);
      check("dump_hold_valid", 64'(dump_valid), 64'd1);
      @(posedge clk); #1;
    end
    dump_ready = 1'b1;
    for (int i = 0; i < MD; i++) begin
      check("dump_row", 64'(dump_row), 64'(i));
      check("dump_data", dump_data, (i == 3) ? 64'h18 : 64'h0);
      @(posedge clk); #1;
    end
    dump_ready = 1'b0;
    check("fin_finished", 64'(finished), 64'd1);
    check("fin_dump_valid", 64'(dump_valid), 64'd0);
    check("fin_vcount", 64'(visit_count), 64'd2);
    row = 9; col = 9; maze_we = 1'b1;
    @(posedge clk); #1;
    maze_we = 1'b0;
    check("fin_vcount_frozen", 64'(visit_count), 64'd2);
    check("fin_sticky", 64'(finished), 64'd1);

    rst = 1'b1; #1;
    check("rfin_finished", 64'(finished), 64'd0);
    check("rfin_vcount", 64'(visit_count), 64'd0);
    check("rfin_loaded", 64'(loaded), 64'd0);
    release_rst();

    load_rows(10, 1, 1'b0, rdy, cyc);
    rst = 1'b1; #1;
    check("mid_load_ready", 64'(load_ready), 64'd0);
    check("mid_loaded", 64'(loaded), 64'd0);
    release_rst();

    load_rows(MD, 2, 1'b1, rdy, cyc);
    check("bp_ready_cycles", 64'(rdy), 64'd128);
    check("bp_cycles", 64'(cyc), 64'd129);
    check("bp_loaded", 64'(loaded), 64'd1);
    check("bp_vcount", 64'(visit_count), 64'd0);
    do_read(0, 5, 1'b0, "bp_rd_0_5");
    do_read(0, 0, 1'b1, "bp_rd_0_0");
    do_read(3, 3, 1'b1, "bp_rd_3_3");
    do_read(3, 4, 1'b0, "bp_rd_3_4");
    do_read(9, 2, 1'b0, "bp_rd_9_2");
    do_read(40, 40, 1'b1, "bp_rd_40_40");
    do_read(63, 63, 1'b1, "bp_rd_63_63");
    do_read(62, 63, 1'b0, "bp_rd_62_63");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
